// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with shadow/display buffering committed at frame boundaries.
// Optional build macro SEG7_HEX_MODE_EN adds A-F glyphs for codes 10-15.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    load_ack
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    term;
    logic                    frame;

    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    shadow_blank;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    disp_blank;

    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_lz;
    logic                    all_zero;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [NUM_DIGITS-1:0]   en_next;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
`ifdef SEG7_HEX_MODE_EN
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b0000011;
            4'd12:   s = 7'b1000110;
            4'd13:   s = 7'b0100001;
            4'd14:   s = 7'b0000110;
            4'd15:   s = 7'b0001110;
`endif
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign term  = (cnt == CW'(SCAN_DIV - 1));
    assign frame = term && (idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (term) begin
            cnt <= '0;
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A strobe landing exactly on the frame boundary bypasses the shadow and commits at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= 1'b0;
            pending      <= 1'b0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_blank   <= 1'b0;
            load_ack     <= 1'b0;
        end else begin
            load_ack <= frame && (pending || load);
            if (frame) begin
                pending <= 1'b0;
                if (load) begin
                    disp_value <= value;
                    disp_dp    <= dp;
                    disp_blank <= blank;
                end else if (pending) begin
                    disp_value <= shadow_value;
                    disp_dp    <= shadow_dp;
                    disp_blank <= shadow_blank;
                end
            end else if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp;
                shadow_blank <= blank;
                pending      <= 1'b1;
            end
        end
    end

    // zero_from[k] is set when digit k and every more significant digit hold code 0.
    always_comb begin
        cur_code  = 4'd0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        all_zero  = 1'b1;
        zero_from = '0;
        en_next   = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero     = all_zero && (disp_value[4*k +: 4] == 4'd0);
            zero_from[k] = all_zero;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_code   = disp_value[4*k +: 4];
                cur_dp     = disp_dp[k];
                cur_lz     = (LZ_BLANK != 0) && (k != 0) && zero_from[k];
                en_next[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || disp_blank) begin
            seg      <= 7'h7F;
            seg_dp   <= 1'b1;
            digit_en <= '1;
        end else begin
            seg      <= cur_lz ? 7'h7F : decode(cur_code);
            seg_dp   <= ~cur_dp;
            digit_en <= en_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4, LZ_BLANK=1; one 16-cycle frame per stimulus call.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  digit_en;
    logic        load_ack;

    int checkCount = 0;
    int passCount  = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef SEG7_HEX_MODE_EN
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
`else
    localparam logic [6:0] SA = 7'b1000000;
    localparam logic [6:0] SF = 7'b1000000;
`endif

    seg7_scan_driver #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4),
        .LZ_BLANK  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .value   (value),
        .dp      (dp),
        .blank   (blank),
        .seg     (seg),
        .seg_dp  (seg_dp),
        .digit_en(digit_en),
        .load_ack(load_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs are packed as {3'b0, load_ack, seg_dp, digit_en, seg}.
    task automatic resetCycles(input string name, input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            checkOutput($sformatf("%s i=%0d", name, i),
                        {3'b000, load_ack, seg_dp, digit_en, seg},
                        {3'b000, 1'b0, 1'b1, 4'b1111, 7'h7F});
        end
        rst   = 1'b0;
        load  = 1'b0;
        value = 16'h0000;
        dp    = 4'b0000;
        blank = 1'b0;
    endtask

    // Runs nsteps cycles of a frame; segs holds {digit3..digit0}; load slots la/lb are cycle indices or -1.
    task automatic applyStimulus(input string name, input int nsteps, input logic [27:0] segs,
                                 input logic [3:0] dpm, input logic blk, input logic ackExp,
                                 input int la, input logic [15:0] va, input logic [3:0] da,
                                 input logic ba, input int lb, input logic [15:0] vb);
        for (int j = 0; j < nsteps; j++) begin
            int          d;
            logic        ackBit;
            logic [15:0] expv;
            load = 1'b0;
            if (j == la) begin
                load  = 1'b1;
                value = va;
                dp    = da;
                blank = ba;
            end else if (j == lb) begin
                load  = 1'b1;
                value = vb;
                dp    = 4'b0000;
                blank = 1'b0;
            end
            step();
            d      = j / 4;
            ackBit = (j == 15) ? ackExp : 1'b0;
            if (blk) expv = {3'b000, ackBit, 1'b1, 4'b1111, 7'h7F};
            else     expv = {3'b000, ackBit, ~dpm[d], ~(4'b0001 << d), segs[7*d +: 7]};
            checkOutput($sformatf("%s j=%0d", name, j),
                        {3'b000, load_ack, seg_dp, digit_en, seg}, expv);
        end
        load = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b1;
        value = 16'h9999;
        dp    = 4'b1111;
        blank = 1'b1;
        resetCycles("reset_init", 3);

        applyStimulus("f0_idle",        16, {SB, SB, SB, S0}, 4'b0000, 1'b0, 1'b0,
                      -1, 16'h0000, 4'b0000, 1'b0, -1, 16'h0000);
        applyStimulus("f1_load0307",    16, {SB, SB, SB, S0}, 4'b0000, 1'b0, 1'b1,
                      5, 16'h0307, 4'b0000, 1'b0, -1, 16'h0000);
        applyStimulus("f2_show0307",    16, {SB, S3, S0, S7}, 4'b0000, 1'b0, 1'b1,
                      2, 16'h1111, 4'b0000, 1'b0, 9, 16'h2222);
        applyStimulus("f3_show2222",    16, {S2, S2, S2, S2}, 4'b0000, 1'b0, 1'b1,
                      15, 16'h00AF, 4'b0100, 1'b0, -1, 16'h0000);
        applyStimulus("f4_show00af",    16, {SB, SB, SA, SF}, 4'b0100, 1'b0, 1'b1,
                      3, 16'h1234, 4'b0000, 1'b1, -1, 16'h0000);
        applyStimulus("f5_blank",       10, 28'h0,            4'b0000, 1'b1, 1'b0,
                      4, 16'h0050, 4'b0000, 1'b0, -1, 16'h0000);
        resetCycles("reset_mid", 2);
        applyStimulus("f6_after_reset", 16, {SB, SB, SB, S0}, 4'b0000, 1'b0, 1'b0,
                      -1, 16'h0000, 4'b0000, 1'b0, -1, 16'h0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: CLK cycles each digit is lit, legal range 2..2^20.
REQ-003 Parameter LZ_BLANK, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-004 CLK  input  1  single clock; all logic on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 LOAD_IN  input  1  one-cycle strobe that captures VALUE_IN, DP_IN and BLANK_IN.
REQ-007 VALUE_IN  input  4*NUM_DIGITS  nibble k is the code for digit k; digit 0 is least significant.
REQ-008 DP_IN  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-009 BLANK_IN  input  1  1 blanks the whole display.
REQ-010 SEG_OUT  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 DP_OUT  output  1  decimal point, active-low, registered.
REQ-012 DIGIT_EN_OUT  output  NUM_DIGITS  digit enables, active-low, at most one bit low, registered.
REQ-013 LOAD_ACK_OUT  output  1  one-cycle pulse when a captured load reaches the display.

Function
REQ-014 The block SHALL hold a shadow register and a display register; the scan reads only the display register.
REQ-015 A LOAD_IN strobe SHALL write the shadow register and set a pending flag; a later strobe before commit overwrites the shadow (newest wins).
REQ-016 The scan counter SHALL count 0..SCAN_DIV-1; at terminal count the digit index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-017 The frame boundary SHALL be terminal count with index NUM_DIGITS-1; there, if pending, display <= shadow, pending clears, and LOAD_ACK_OUT SHALL be 1 in the next cycle.
REQ-018 If LOAD_IN coincides with the frame boundary, the new inputs SHALL commit directly at that boundary.
REQ-019 Outputs SHALL reflect the scan state with a latency of one cycle; DIGIT_EN_OUT bit idx low and all other bits high.
REQ-020 Decoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 With LZ_BLANK=1, a digit k>0 whose code and all higher codes are 0 SHALL output SEG_OUT=1111111; digit 0 is never zero-blanked.
REQ-022 A zero-blanked digit SHALL still show its DP if its DP bit is requested.
REQ-023 With display BLANK set, SEG_OUT=1111111, DP_OUT=1 and DIGIT_EN_OUT all 1; the scan counter keeps running.
REQ-024 The digit enable SHALL change in the same cycle as the segments (no mixed-digit cycle).

Reset
REQ-025 While RST=1: SEG_OUT=1111111, DP_OUT=1, DIGIT_EN_OUT all 1, LOAD_ACK_OUT=0.
REQ-026 While RST=1: counter=0, index=0, shadow=0, display=0, DP=0, BLANK=0, pending=0; LOAD_IN is ignored.
REQ-027 The first cycle after RST falls SHALL show digit 0 lit with 1000000.
REQ-028 RST asserted mid-frame SHALL discard a pending load with no LOAD_ACK_OUT pulse.

Configuration
REQ-029 Macro SEG7_HEX_MODE_EN defined: codes 10-15 SHALL decode to A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-030 Macro SEG7_HEX_MODE_EN undefined: codes 10-15 SHALL decode to 1000000 ("0"), while leading-zero blanking still treats them as non-zero.

Verification (NUM_DIGITS=4, SCAN_DIV=4, LZ_BLANK=1)
REQ-031 Reset release, no load -> DIGIT_EN_OUT=1110 with SEG_OUT=1000000; digits 1-3 blank; each digit held 4 cycles; period 16 cycles.
REQ-032 LOAD_IN with VALUE_IN=16'h0307 at cycle 5 -> display unchanged until the frame boundary at cycle 15; LOAD_ACK_OUT=1 at cycle 16; digit0=1111000, digit1=1000000, digit2=0110000, digit3=1111111.
REQ-033 Two loads, 16'h1111 then 16'h2222, in one frame -> only 2222 is shown; a single LOAD_ACK_OUT pulse.
REQ-034 LOAD_IN with VALUE_IN=16'h00AF and DP_IN=0100 -> with SEG7_HEX_MODE_EN: 0001110, 0001000, DP only, blank; without SEG7_HEX_MODE_EN: 1000000, 1000000, DP only, blank.
REQ-035 BLANK_IN=1 loaded, then RST pulsed while a load is pending -> all outputs are off; no LOAD_ACK_OUT; after reset, digit 0 shows 1000000.
